// File: rtl/bsg_bladerunner_mem_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bsg_bladerunner_mem_cfg_pkg
// Purpose : Memory-config codes, decoded level codes and register-map constants
// Revision: 1.0
// ============================================================================
package bsg_bladerunner_mem_cfg_pkg;

    localparam int c_lg_max_cfgs = 7;

    typedef enum logic [c_lg_max_cfgs-1:0] {
        e_infinite_mem = 7'd0,
        e_blk_f1_dram  = 7'd1,
        e_blk_f1_model = 7'd2,
        e_nb_f1_dram   = 7'd3,
        e_nb_f1_model  = 7'd4,
        e_nb_dramsim3  = 7'd5,
        e_blk_dramsim3 = 7'd6
    } bsg_bladerunner_mem_cfg_e;

    typedef enum logic [3:0] {
        e_l1_infinite_mem        = 4'd0,
        e_l1_vcache_blocking     = 4'd1,
        e_l1_vcache_non_blocking = 4'd2,
        e_l1_invalid             = 4'hF
    } l1_code_e;

    typedef enum logic [3:0] {
        e_l2_none      = 4'd0,
        e_l2_axi4      = 4'd1,
        e_l2_test_dram = 4'd2,
        e_l2_invalid   = 4'hF
    } l2_code_e;

    typedef enum logic [3:0] {
        e_l3_none                   = 4'd0,
        e_l3_f1_dram                = 4'd1,
        e_l3_f1_model               = 4'd2,
        e_l3_dramsim3_hbm2_4gb_x128 = 4'd3,
        e_l3_invalid                = 4'hF
    } l3_code_e;

    typedef enum logic [0:0] {
        eEmpty = 1'b0,
        eFull  = 1'b1
    } resp_state_e;

    localparam logic [31:0] c_magic = 32'h4D45_4D43;

    localparam int c_word_magic    = 0;
    localparam int c_word_cfg      = 1;
    localparam int c_word_l1       = 2;
    localparam int c_word_l2       = 3;
    localparam int c_word_l3       = 4;
    localparam int c_word_channels = 5;
    localparam int c_word_served   = 6;
    localparam int c_word_check    = 7;
    localparam int c_num_words     = 8;

endpackage
`default_nettype wire

// File: rtl/bsg_bladerunner_mem_cfg_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : bsg_bladerunner_mem_cfg_responder_if
// Purpose : Read request / response handshake bundle of the config responder
// Revision: 1.0
// ============================================================================
interface bsg_bladerunner_mem_cfg_responder_if #(
    parameter int addr_width_p = 3,
    parameter int data_width_p = 32
) ();
    logic                    v_i;
    logic [addr_width_p-1:0] addr_i;
    logic                    ready_o;
    logic                    v_o;
    logic [data_width_p-1:0] data_o;
    logic                    err_o;
    logic                    ready_i;

    modport master (
        output v_i, addr_i, ready_i,
        input  ready_o, v_o, data_o, err_o
    );

    modport slave (
        input  v_i, addr_i, ready_i,
        output ready_o, v_o, data_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/bsg_bladerunner_mem_cfg_decode.sv
`default_nettype none
// ============================================================================
// Module  : bsg_bladerunner_mem_cfg_decode
// Purpose : Combinational config code -> {L1, L2, L3, invalid} decode
// Revision: 1.0
// ============================================================================
module bsg_bladerunner_mem_cfg_decode
    import bsg_bladerunner_mem_cfg_pkg::*;
#(
    parameter int lg_max_cfgs_p = c_lg_max_cfgs
) (
    input  wire logic [lg_max_cfgs_p-1:0] i_cfg,
    output logic      [3:0]               o_l1,
    output logic      [3:0]               o_l2,
    output logic      [3:0]               o_l3,
    output logic                          o_invalid
);

    always_comb begin
        o_l1      = e_l1_invalid;
        o_l2      = e_l2_invalid;
        o_l3      = e_l3_invalid;
        o_invalid = 1'b0;
        case (i_cfg)
            e_infinite_mem: begin
                o_l1 = e_l1_infinite_mem;
                o_l2 = e_l2_none;
                o_l3 = e_l3_none;
            end
            e_blk_f1_dram: begin
                o_l1 = e_l1_vcache_blocking;
                o_l2 = e_l2_axi4;
                o_l3 = e_l3_f1_dram;
            end
            e_blk_f1_model: begin
                o_l1 = e_l1_vcache_blocking;
                o_l2 = e_l2_axi4;
                o_l3 = e_l3_f1_model;
            end
            e_nb_f1_dram: begin
                o_l1 = e_l1_vcache_non_blocking;
                o_l2 = e_l2_axi4;
                o_l3 = e_l3_f1_dram;
            end
            e_nb_f1_model: begin
                o_l1 = e_l1_vcache_non_blocking;
                o_l2 = e_l2_axi4;
                o_l3 = e_l3_f1_model;
            end
            e_nb_dramsim3: begin
                o_l1 = e_l1_vcache_non_blocking;
                o_l2 = e_l2_test_dram;
                o_l3 = e_l3_dramsim3_hbm2_4gb_x128;
            end
            e_blk_dramsim3: begin
                o_l1 = e_l1_vcache_blocking;
                o_l2 = e_l2_test_dram;
                o_l3 = e_l3_dramsim3_hbm2_4gb_x128;
            end
            default: o_invalid = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bsg_bladerunner_mem_cfg_responder.sv
`default_nettype none
// ============================================================================
// Module  : bsg_bladerunner_mem_cfg_responder
// Purpose : Read-only host register file describing the memory configuration
// Revision: 1.0
// ============================================================================
module bsg_bladerunner_mem_cfg_responder
    import bsg_bladerunner_mem_cfg_pkg::*;
#(
    parameter int addr_width_p   = 3,
    parameter int data_width_p   = 32,
    parameter int num_channels_p = 1,
    parameter int lg_max_cfgs_p  = c_lg_max_cfgs
) (
    input  wire logic                     clk_i,
    input  wire logic                     reset_n_i,
    input  wire logic [lg_max_cfgs_p-1:0] mem_cfg_i,
    bsg_bladerunner_mem_cfg_responder_if.slave bus
);

    resp_state_e             r_state;
    resp_state_e             w_state_next;
    logic [lg_max_cfgs_p-1:0] r_mem_cfg;
    logic [data_width_p-1:0] r_data;
    logic                    r_err;
    logic [data_width_p-1:0] r_served;

    logic                    w_accept;
    logic                    w_consume;
    logic                    w_addr_bad;
    logic [3:0]              w_l1;
    logic [3:0]              w_l2;
    logic [3:0]              w_l3;
    logic                    w_invalid;
    logic [data_width_p-1:0] w_words [c_num_words];
    logic [data_width_p-1:0] w_data_next;
    logic                    w_err_next;

    assign bus.ready_o = (r_state == eEmpty) | bus.ready_i;
    assign bus.v_o     = (r_state == eFull);
    assign bus.data_o  = r_data;
    assign bus.err_o   = r_err;

    assign w_accept  = bus.v_i & bus.ready_o;
    assign w_consume = (r_state == eFull) & bus.ready_i;

    bsg_bladerunner_mem_cfg_decode #(
        .lg_max_cfgs_p (lg_max_cfgs_p)
    ) u_decode (
        .i_cfg     (r_mem_cfg),
        .o_l1      (w_l1),
        .o_l2      (w_l2),
        .o_l3      (w_l3),
        .o_invalid (w_invalid)
    );

    // Only wider address buses can name a word beyond the eight implemented.
    if (addr_width_p > 3) begin : g_wide_addr
        assign w_addr_bad = |bus.addr_i[addr_width_p-1:3];
    end else begin : g_narrow_addr
        assign w_addr_bad = 1'b0;
    end

    always_comb begin
        w_words[c_word_magic]    = data_width_p'(c_magic);
        w_words[c_word_cfg]      = data_width_p'(r_mem_cfg) | (data_width_p'(w_invalid) << 31);
        w_words[c_word_l1]       = data_width_p'(w_l1);
        w_words[c_word_l2]       = data_width_p'(w_l2);
        w_words[c_word_l3]       = data_width_p'(w_l3);
        w_words[c_word_channels] = data_width_p'(num_channels_p);
        w_words[c_word_served]   = r_served;
        w_words[c_word_check]    = w_words[c_word_magic] ^ w_words[c_word_cfg]
                                 ^ w_words[c_word_l1] ^ w_words[c_word_l2]
                                 ^ w_words[c_word_l3] ^ w_words[c_word_channels];
    end

    assign w_data_next = w_addr_bad ? '0 : w_words[bus.addr_i[2:0]];
    assign w_err_next  = w_addr_bad | w_invalid;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= eEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            eEmpty:  if (w_accept) w_state_next = eFull;
            eFull:   if (w_consume && !w_accept) w_state_next = eEmpty;
            default: w_state_next = eEmpty;
        endcase
    end

    // The served count is sampled before this cycle's consume lands.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_mem_cfg <= '0;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_served  <= '0;
        end else begin
            r_mem_cfg <= mem_cfg_i;
            if (w_accept) begin
                r_data <= w_data_next;
                r_err  <= w_err_next;
            end
            if (w_consume && !(&r_served)) begin
                r_served <= r_served + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_bladerunner_mem_cfg_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_bsg_bladerunner_mem_cfg_responder
// Purpose : Directed + random bench with a transaction-level reference model
// Revision: 1.0
// ============================================================================
module tb_bsg_bladerunner_mem_cfg_responder;

    localparam int L1_T [7] = '{0, 1, 1, 2, 2, 2, 1};
    localparam int L2_T [7] = '{0, 1, 1, 1, 1, 2, 2};
    localparam int L3_T [7] = '{0, 1, 2, 1, 2, 3, 3};
    localparam logic [31:0] PLAN5 [6] = '{32'h4D45_4D43, 32'd5, 32'd2, 32'd2, 32'd3, 32'd1};

    logic       clk_i;
    logic       reset_n_i;
    logic [6:0] mem_cfg_i;

    bsg_bladerunner_mem_cfg_responder_if #(.addr_width_p(3), .data_width_p(32)) bus ();

    bsg_bladerunner_mem_cfg_responder #(
        .addr_width_p   (3),
        .data_width_p   (32),
        .num_channels_p (1),
        .lg_max_cfgs_p  (7)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .mem_cfg_i (mem_cfg_i),
        .bus       (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          tests = 0;
    int          fails = 0;
    logic        m_full;
    logic [31:0] m_data;
    logic        m_err;
    logic [31:0] m_served;
    logic [6:0]  m_cfg_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [2:0] a, input logic [6:0] cfg,
                                             input logic [31:0] served, output logic err);
        logic [31:0] w [8];
        logic        inv;
        inv  = (cfg > 7'd6);
        w[0] = 32'h4D45_4D43;
        w[1] = {inv, 24'd0, cfg};
        if (inv) begin
            w[2] = 32'hF; w[3] = 32'hF; w[4] = 32'hF;
        end else begin
            w[2] = L1_T[cfg]; w[3] = L2_T[cfg]; w[4] = L3_T[cfg];
        end
        w[5] = 32'd1;
        w[6] = served;
        w[7] = w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[4] ^ w[5];
        err  = inv;
        return w[a];
    endfunction

    // One clock: check ready_o, advance the model across the edge, check response.
    task automatic tick();
        logic acc, cons, e;
        #1;
        chk("ready_o", {31'd0, bus.ready_o}, {31'd0, (!m_full) | bus.ready_i});
        acc  = bus.v_i & ((!m_full) | bus.ready_i);
        cons = m_full & bus.ready_i;
        @(posedge clk_i);
        if (acc) begin
            m_data = ref_word(bus.addr_i, m_cfg_r, m_served, e);
            m_err  = e;
        end
        if (cons && m_served != 32'hFFFF_FFFF) m_served = m_served + 1;
        m_full  = acc | (m_full & !cons);
        m_cfg_r = mem_cfg_i;
        #1;
        chk("v_o", {31'd0, bus.v_o}, {31'd0, m_full});
        if (m_full) begin
            chk("data_o", bus.data_o, m_data);
            chk("err_o", {31'd0, bus.err_o}, {31'd0, m_err});
        end
    endtask

    task automatic req(input logic [2:0] a, input logic rdy);
        bus.v_i = 1'b1; bus.addr_i = a; bus.ready_i = rdy;
        tick();
    endtask

    task automatic idle(input logic rdy);
        bus.v_i = 1'b0; bus.ready_i = rdy;
        tick();
    endtask

    task automatic model_reset();
        m_full = 1'b0; m_data = '0; m_err = 1'b0; m_served = '0; m_cfg_r = '0;
    endtask

    initial begin
        reset_n_i  = 1'b0;
        mem_cfg_i  = 7'd5;
        bus.v_i    = 1'b0;
        bus.addr_i = '0;
        bus.ready_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_v_o", {31'd0, bus.v_o}, 32'd0);
        chk("rst_data_o", bus.data_o, 32'd0);
        chk("rst_err_o", {31'd0, bus.err_o}, 32'd0);
        reset_n_i = 1'b1;

        // nb_dramsim3: full word map, one read per cycle
        idle(1'b1); idle(1'b1);
        for (int k = 0; k < 8; k++) begin
            req(k[2:0], 1'b1);
            if (k < 6) chk("plan_cfg5", bus.data_o, PLAN5[k]);
            if (k == 6) chk("plan_served", bus.data_o, 32'd5);
        end
        idle(1'b1);

        // blk_f1_dram: v_i held high, eight back-to-back responses
        mem_cfg_i = 7'd1;
        idle(1'b1); idle(1'b1);
        for (int k = 0; k < 8; k++) req(k[2:0], 1'b1);
        idle(1'b1);

        // backpressure: response held, no further accepts
        req(3'd2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            req(3'd5, 1'b0);
            chk("bp_hold", bus.data_o, 32'd1);
        end
        req(3'd5, 1'b1);
        idle(1'b1);

        // invalid code
        mem_cfg_i = 7'h40;
        idle(1'b1); idle(1'b1);
        for (int k = 0; k < 8; k++) begin
            req(k[2:0], 1'b1);
            if (k == 1) chk("inv_word1", bus.data_o, 32'h8000_0040);
            if (k >= 2 && k <= 4) chk("inv_level", bus.data_o, 32'hF);
        end
        idle(1'b1);

        // async reset while a response is pending
        mem_cfg_i = 7'd3;
        req(3'd3, 1'b0);
        #2;
        reset_n_i = 1'b0;
        #1;
        model_reset();
        chk("async_v_o", {31'd0, bus.v_o}, 32'd0);
        chk("async_data_o", bus.data_o, 32'd0);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        idle(1'b1); idle(1'b1);
        req(3'd6, 1'b1);
        chk("served_after_rst", bus.data_o, 32'd0);
        idle(1'b1);

        // config change 2 -> 6 while idle
        mem_cfg_i = 7'd2;
        idle(1'b1); idle(1'b1);
        mem_cfg_i = 7'd6;
        idle(1'b1);
        req(3'd2, 1'b1);
        chk("cfg_change_l1", bus.data_o, 32'd1);
        idle(1'b1);

        // random traffic with occasional config changes
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                mem_cfg_i = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(7, 127))
                                                        : 7'($urandom_range(0, 6));
            end
            bus.v_i     = 1'($urandom_range(0, 1));
            bus.addr_i  = 3'($urandom_range(0, 7));
            bus.ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
